// File: rtl/atan2.sv
`default_nettype none
// ============================================================================
// Module   : atan2
// Purpose  : Iterative CORDIC in vectoring mode. Turns a fixed-point vector
//            (x, y) into its angle atan2(y, x) and its gain-compensated
//            magnitude sqrt(x^2 + y^2). The angle format matches the one the
//            sin/cos blocks consume (FRAC fractional bits, PI = 205887).
// Ports    : clk, rst         - clock, synchronous active-high reset
//            in_valid/in_ready - input handshake (ready only while idle)
//            x, y              - signed W-bit input vector
//            out_valid/out_ready - result handshake (held until accepted)
//            angle             - signed W-bit angle, range (-PI, PI]
//            mag               - signed W-bit magnitude, >= 0, saturating
// Revision : 1.0 - initial release
// ============================================================================
module atan2 #(
  parameter int W     = 32,
  parameter int FRAC  = 16,
  parameter int ITERS = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [W-1:0] x,
  input  logic signed [W-1:0] y,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [W-1:0] angle,
  output logic signed [W-1:0] mag
);

  // Two guard bits absorb the CORDIC gain (~1.647 * sqrt(2)) without overflow.
  localparam int IW   = W + 2;
  localparam int IDXW = (ITERS > 1) ? $clog2(ITERS) : 1;
  // Product width: IW-bit signed vector times an unsigned 17-bit gain constant.
  localparam int PW   = IW + 18;

  localparam logic signed [IW-1:0] C_HALF_PI = IW'(102944);
  localparam logic signed [PW-1:0] C_KINV    = PW'(39797);
  localparam logic signed [PW-1:0] C_MAG_MAX = {{(PW-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic [IDXW-1:0]      C_LAST    = IDXW'(ITERS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_PREROT = 3'd1,
    S_ITER   = 3'd2,
    S_SCALE  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  // round(atan(2^-i) * 2^16); the angle format is fixed at 16 fractional bits.
  function automatic int atan_q16(input int idx);
    case (idx)
      0:       return 51472;
      1:       return 30386;
      2:       return 16055;
      3:       return 8150;
      4:       return 4091;
      5:       return 2047;
      6:       return 1024;
      7:       return 512;
      8:       return 256;
      9:       return 128;
      10:      return 64;
      11:      return 32;
      12:      return 16;
      13:      return 8;
      14:      return 4;
      15:      return 2;
      default: return 0;
    endcase
  endfunction

  state_t                 state_q, state_d;
  logic signed [IW-1:0]   xr_q, xr_d;
  logic signed [IW-1:0]   yr_q, yr_d;
  logic signed [IW-1:0]   z_q, z_d;
  logic [IDXW-1:0]        iter_q, iter_d;
  logic                   zero_q, zero_d;
  logic signed [W-1:0]    angle_q, angle_d;
  logic signed [W-1:0]    mag_q, mag_d;

  logic signed [IW-1:0]   w_xsh;
  logic signed [IW-1:0]   w_ysh;
  logic signed [IW-1:0]   w_atan;
  logic signed [PW-1:0]   w_xr_ext;
  logic signed [PW-1:0]   w_prod;
  logic signed [PW-1:0]   w_scaled;
  logic signed [W-1:0]    w_mag_sat;

  // Micro-rotation operands, always from the pre-update xr/yr.
  assign w_xsh  = xr_q >>> iter_q;
  assign w_ysh  = yr_q >>> iter_q;
  assign w_atan = IW'(atan_q16(int'(iter_q)));

  // Gain compensation and saturation of the magnitude.
  assign w_xr_ext = {{(PW-IW){xr_q[IW-1]}}, xr_q};
  assign w_prod   = w_xr_ext * C_KINV;
  assign w_scaled = w_prod >>> FRAC;

  always_comb begin
    w_mag_sat = w_scaled[W-1:0];
    if (w_scaled[PW-1]) begin
      w_mag_sat = '0;
    end else if (w_scaled > C_MAG_MAX) begin
      w_mag_sat = C_MAG_MAX[W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      xr_q    <= '0;
      yr_q    <= '0;
      z_q     <= '0;
      iter_q  <= '0;
      zero_q  <= 1'b0;
      angle_q <= '0;
      mag_q   <= '0;
    end else begin
      state_q <= state_d;
      xr_q    <= xr_d;
      yr_q    <= yr_d;
      z_q     <= z_d;
      iter_q  <= iter_d;
      zero_q  <= zero_d;
      angle_q <= angle_d;
      mag_q   <= mag_d;
    end
  end

  always_comb begin
    state_d = state_q;
    xr_d    = xr_q;
    yr_d    = yr_q;
    z_d     = z_q;
    iter_d  = iter_q;
    zero_d  = zero_q;
    angle_d = angle_q;
    mag_d   = mag_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          xr_d    = {{2{x[W-1]}}, x};
          yr_d    = {{2{y[W-1]}}, y};
          // The origin has no defined direction; the iterations would
          // otherwise accumulate the whole ATAN table into z.
          zero_d  = (x == '0) && (y == '0);
          state_d = S_PREROT;
        end
      end

      S_PREROT: begin
        // Fold into the right half-plane so the iterations converge.
        if (!xr_q[IW-1]) begin
          z_d = '0;
        end else if (!yr_q[IW-1]) begin
          xr_d = yr_q;
          yr_d = -xr_q;
          z_d  = C_HALF_PI;
        end else begin
          xr_d = -yr_q;
          yr_d = xr_q;
          z_d  = -C_HALF_PI;
        end
        iter_d  = '0;
        state_d = S_ITER;
      end

      S_ITER: begin
        if (!yr_q[IW-1]) begin
          xr_d = xr_q + w_ysh;
          yr_d = yr_q - w_xsh;
          z_d  = z_q + w_atan;
        end else begin
          xr_d = xr_q - w_ysh;
          yr_d = yr_q + w_xsh;
          z_d  = z_q - w_atan;
        end
        if (iter_q == C_LAST) begin
          state_d = S_SCALE;
        end else begin
          iter_d = iter_q + IDXW'(1);
        end
      end

      S_SCALE: begin
        mag_d   = w_mag_sat;
        angle_d = zero_q ? '0 : z_q[W-1:0];
        state_d = S_DONE;
      end

      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign in_ready  = (state_q == S_IDLE) && !rst;
  assign out_valid = (state_q == S_DONE);
  assign angle     = angle_q;
  assign mag       = mag_q;

endmodule
`default_nettype wire

// File: tb/tb_atan2.sv
`default_nettype none
// ============================================================================
// Module   : tb_atan2
// Purpose  : Self-checking bench for the atan2 CORDIC block: reset values,
//            latency, quadrant folding, boundary vectors, backpressure,
//            mid-computation reset and a randomised regression against a
//            real-valued atan2/sqrt model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_atan2;

  localparam int W = 32;

  logic                clk;
  logic                rst;
  logic                in_valid;
  logic                in_ready;
  logic signed [W-1:0] x;
  logic signed [W-1:0] y;
  logic                out_valid;
  logic                out_ready;
  logic signed [W-1:0] angle;
  logic signed [W-1:0] mag;

  int checks = 0;
  int errors = 0;

  atan2 #(.W(W), .FRAC(16), .ITERS(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .angle     (angle),
    .mag       (mag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int adiff(input int a, input int b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

  // Presents one vector and returns #1 after the accept edge; x/y are then
  // scrambled so a design that re-samples them would be caught.
  task automatic send(input int vx, input int vy, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      x        = vx;
      y        = vy;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      x        = 32'sd777777;
      y        = -32'sd333333;
    end
  endtask

  // Waits for a result and takes it; returns #1 after the transfer edge.
  task automatic recv(output int a, output int m, output bit ok, input bit rnd);
    ok = 1'b0;
    a  = 0;
    m  = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (out_valid && out_ready) begin
        a  = angle;
        m  = mag;
        ok = 1'b1;
        @(posedge clk);
        #1;
        break;
      end
    end
    out_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    x         = '0;
    y         = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_handshake: in_ready=%b out_valid=%b expected 0/0", in_ready, out_valid);
    end
    checks++;
    if (angle !== 32'sd0 || mag !== 32'sd0) begin
      errors++;
      $display("FAIL reset_outputs: angle=%0d mag=%0d expected 0/0", angle, mag);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: in_ready=%b expected 1", in_ready);
    end
  endtask

  task automatic test_basic_45();
    bit ok;
    int lat;
    int a;
    int m;
    lat = -1;
    a   = 0;
    m   = 0;
    send(65536, 65536, ok);
    if (ok) begin
      for (int c = 1; c <= 40; c++) begin
        @(posedge clk);
        #1;
        if (out_valid) begin
          lat = c;
          a   = angle;
          m   = mag;
          break;
        end
      end
    end
    checks++;
    if (lat != 18) begin
      errors++;
      $display("FAIL basic_latency: got %0d cycles expected 18", lat);
    end
    checks++;
    if (adiff(a, 51472) > 8) begin
      errors++;
      $display("FAIL basic_angle: got %0d expected 51472+-8", a);
    end
    checks++;
    if (adiff(m, 92682) > 10) begin
      errors++;
      $display("FAIL basic_mag: got %0d expected 92682+-10", m);
    end
    // out_ready is high, so the result is taken on the next edge.
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL basic_release: out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_quadrants();
    int xs [4] = '{-65536, -65536,      0,       0};
    int ys [4] = '{ 65536, -65536,  65536,  -65536};
    int ex [4] = '{154415, -154415, 102944, -102944};
    bit ok;
    int a;
    int m;
    for (int i = 0; i < 4; i++) begin
      send(xs[i], ys[i], ok);
      if (ok) recv(a, m, ok, 1'b0);
      checks++;
      if (!ok || adiff(a, ex[i]) > 8) begin
        errors++;
        $display("FAIL quadrant_%0d: ok=%0d angle=%0d expected %0d+-8", i, ok, a, ex[i]);
      end
    end
  endtask

  task automatic test_boundaries();
    bit ok;
    int a;
    int m;
    send(-65536, 0, ok);
    if (ok) recv(a, m, ok, 1'b0);
    checks++;
    if (!ok || a <= 0 || adiff(a, 205887) > 8) begin
      errors++;
      $display("FAIL neg_x_axis: ok=%0d angle=%0d expected +205887+-8", ok, a);
    end
    checks++;
    if (!ok || adiff(m, 65536) > 8) begin
      errors++;
      $display("FAIL neg_x_axis_mag: ok=%0d mag=%0d expected 65536+-8", ok, m);
    end

    send(0, 0, ok);
    if (ok) recv(a, m, ok, 1'b0);
    checks++;
    if (!ok || a != 0 || m != 0) begin
      errors++;
      $display("FAIL origin: ok=%0d angle=%0d mag=%0d expected 0/0", ok, a, m);
    end

    send(32'sd536870912, 0, ok);
    if (ok) recv(a, m, ok, 1'b0);
    checks++;
    if (!ok || adiff(a, 0) > 8) begin
      errors++;
      $display("FAIL large_x_angle: ok=%0d angle=%0d expected 0+-8", ok, a);
    end
    checks++;
    if (!ok || adiff(m, 536870912) > 32768) begin
      errors++;
      $display("FAIL large_x_mag: ok=%0d mag=%0d expected 536870912+-32768", ok, m);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    bit seen;
    int a0;
    int m0;
    seen = 1'b0;
    a0   = 0;
    m0   = 0;
    out_ready = 1'b0;
    send(65536, 65536, ok);
    for (int c = 0; c < 40 && ok; c++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1'b1;
        a0   = angle;
        m0   = mag;
        break;
      end
    end
    checks++;
    if (!seen || adiff(a0, 51472) > 8) begin
      errors++;
      $display("FAIL bp_result: seen=%0d angle=%0d expected 51472+-8", seen, a0);
    end
    for (int c = 0; c < 10; c++) begin
      in_valid = c[0];
      x        = 32'sd1000 + c;
      y        = -32'sd2000;
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || angle !== a0 || mag !== m0) begin
        errors++;
        $display("FAIL bp_hold_%0d: out_valid=%b in_ready=%b angle=%0d mag=%0d expected 1/0/%0d/%0d",
                 c, out_valid, in_ready, angle, mag, a0, m0);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready);
    end
    // Ignored pulses must not have queued a second computation.
    seen = 1'b0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL bp_no_queue: out_valid=1 expected 0");
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    bit seen;
    int a;
    int m;
    send(65536, 65536, ok);
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL midrst_during: out_valid=%b in_ready=%b expected 0/0", out_valid, in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL midrst_ready: in_ready=%b expected 1", in_ready);
    end
    seen = 1'b0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL midrst_aborted: out_valid=1 expected 0");
    end
    send(65536, 0, ok);
    if (ok) recv(a, m, ok, 1'b0);
    checks++;
    if (!ok || adiff(a, 0) > 8 || adiff(m, 65536) > 8) begin
      errors++;
      $display("FAIL midrst_next: ok=%0d angle=%0d mag=%0d expected 0+-8/65536+-8", ok, a, m);
    end
  endtask

  task automatic test_random();
    bit ok;
    int a;
    int m;
    int vx;
    int vy;
    int got;
    real ar;
    real mr;
    real d;
    got = 0;
    for (int n = 0; n < 1000; n++) begin
      // Keep the vector long enough that truncation in the shifts stays
      // well inside the angle tolerance.
      do begin
        vx = int'($urandom_range(0, 8388608)) - 4194304;
        vy = int'($urandom_range(0, 8388608)) - 4194304;
      end while (adiff(vx, 0) < 262144 && adiff(vy, 0) < 262144);
      send(vx, vy, ok);
      if (ok) recv(a, m, ok, 1'b1);
      if (ok) got++;
      ar = $atan2(real'(vy), real'(vx)) * 65536.0;
      mr = $sqrt(real'(vx) * real'(vx) + real'(vy) * real'(vy));
      d  = real'(a) - ar;
      if (d > 205887.0)  d = d - 411774.8;
      if (d < -205887.0) d = d + 411774.8;
      checks++;
      if (!ok || d > 8.0 || d < -8.0) begin
        errors++;
        $display("FAIL rand_angle (%0d,%0d): ok=%0d angle=%0d expected %0.1f+-8", vx, vy, ok, a, ar);
      end
      checks++;
      if (!ok || real'(m) - mr > 8.0 + mr / 16384.0 || mr - real'(m) > 8.0 + mr / 16384.0) begin
        errors++;
        $display("FAIL rand_mag (%0d,%0d): ok=%0d mag=%0d expected %0.1f", vx, vy, ok, m, mr);
      end
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL rand_duplicate: out_valid=%b after transfer expected 0", out_valid);
      end
    end
    checks++;
    if (got != 1000) begin
      errors++;
      $display("FAIL rand_count: got %0d results expected 1000", got);
    end
  endtask

  initial begin
    test_reset();
    test_basic_45();
    test_quadrants();
    test_boundaries();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
